// File: rtl/rs232_pkg.sv
// Shared constants and the pacing-FSM state type for the RS232 echo buffer.
package rs232_pkg;

    // Width of one serial data byte.
    localparam int unsigned BYTE_W = 8;

    // Baud cycles from a Tx start pulse until the transmitter is idle again.
    // This is the minimum legal guard interval.
    localparam int unsigned BAUD_FRAME_CYCLES = 11;

    // Pacing FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_HOLD  = ST_HOLD
    } pace_state_e;

    // Returns 1 when a guard interval is long enough to cover a full Tx frame.
    function automatic logic gap_is_legal(input int unsigned gap);
        return (gap >= BAUD_FRAME_CYCLES);
    endfunction

endpackage

// File: rtl/rs232_fifo_mem.sv
// Byte FIFO: storage array, read/write pointers, occupancy count and full/empty.
// The caller decides when a write or read is legal; this block just applies it.
module rs232_fifo_mem
    import rs232_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [BYTE_W-1:0] o_rd_data,
    output logic [AW:0]       o_count,
    output logic              o_empty,
    output logic              o_full
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW:0]       w_count_next;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Occupancy update: simultaneous write and read cancel out.
    always_comb begin
        w_count_next = r_count;
        unique case ({i_wr_en, i_rd_en})
            2'b10:   w_count_next = r_count + (AW+1)'(1);
            2'b01:   w_count_next = r_count - (AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Head-of-queue byte is read combinationally; the top level registers it.
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/rs232_echo_fifo.sv
// Buffers bytes from the RS232 receiver and paces them out to the transmitter,
// one start pulse per byte followed by a guard interval covering a whole Tx frame.
module rs232_echo_fifo
    import rs232_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    // GAP must be at least BAUD_FRAME_CYCLES (see gap_is_legal).
    parameter int unsigned GAP   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_start,
    input  logic              ovf_clr,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    // Gap counter only needs to hold GAP-1.
    localparam int unsigned GW = (GAP > 2) ? $clog2(GAP) : 1;

    pace_state_e       r_state;
    pace_state_e       w_state_next;
    logic [GW-1:0]     r_gap;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_start;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [BYTE_W-1:0] w_rd_data;
    logic [AW:0]       w_count;
    logic              w_empty;
    logic              w_full;

    // A pop frees a slot in the same edge, so a push into a full FIFO is still
    // accepted when a pop coincides with it.
    assign w_pop  = (r_state == S_IDLE) && !w_empty;
    assign w_push = rx_start && (!w_full || w_pop);
    assign w_drop = rx_start && !w_push;

    rs232_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_mem (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (rx_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Pacing FSM next-state; unknown encodings fall back to IDLE.
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                w_state_next = w_empty ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                w_state_next = (r_gap == '0) ? S_IDLE : S_HOLD;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register, registered tx_start decode and the byte latched on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tx_start <= (w_state_next == S_ISSUE);
            if (w_pop) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

    // Guard-interval counter: loaded in ISSUE, counted down through HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap <= '0;
        end else if (r_state == S_ISSUE) begin
            r_gap <= GW'(GAP - 1);
        end else if ((r_state == S_HOLD) && (r_gap != '0)) begin
            r_gap <= r_gap - GW'(1);
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign count    = w_count;
    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule
